// File: rtl/lenet_layer_sequencer.sv
// LeNet layer sequencer: accepts one image per handshake, starts each layer
// stage in turn, waits for that stage's done, captures the final class and
// holds it until the consumer takes it. A per-stage watchdog raises a sticky
// error if a stage never reports done.
//
// Handshakes: img_valid/img_ready transfer an image on a rising edge where
// both are high; result_valid/result_ready transfer the class the same way.
// result_valid stays high and class_out stays stable until accepted.
module lenet_layer_sequencer #(
  parameter int NUM_STAGES = 7,
  parameter int IDX_W      = 3,
  parameter int TIMEOUT    = 200000,
  parameter int TMR_W      = 18,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  img_valid,
  output logic                  img_ready,
  output logic                  img_load,
  output logic [NUM_STAGES-1:0] stage_start,
  input  logic [NUM_STAGES-1:0] stage_done,
  input  logic [3:0]            class_in,
  output logic [3:0]            class_out,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [IDX_W-1:0]      err_stage,
  input  logic                  err_clear,
  output logic [CNT_W-1:0]      img_count,
  output logic [2:0]            state_dbg
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  logic [2:0]       state;
  logic [IDX_W-1:0] idx;
  logic [TMR_W-1:0] timer;
  logic [IDX_W-1:0] idx_next;
  logic             done_sel;

  // One-hot start vector for a given stage index.
  function automatic logic [NUM_STAGES-1:0] onehot(input logic [IDX_W-1:0] i);
    return NUM_STAGES'(1) << i;
  endfunction

  // Readiness and busy are plain decodes of the state register.
  assign img_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  // Only the done bit of the active stage is ever looked at.
  always_comb begin
    idx_next = idx + IDX_W'(1);
    done_sel = stage_done[idx];
  end

  // Main sequencing FSM; all registered outputs are updated here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      idx          <= '0;
      timer        <= '0;
      img_load     <= 1'b0;
      stage_start  <= '0;
      class_out    <= '0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      err_stage    <= '0;
      img_count    <= '0;
    end else begin
      // Pulses default low so each lasts exactly one cycle.
      img_load    <= 1'b0;
      stage_start <= '0;
      case (state)
        S_IDLE: begin
          if (img_valid) begin
            state    <= S_LOAD;
            idx      <= '0;
            img_load <= 1'b1;
          end
        end
        S_LOAD: begin
          // The start pulse is registered so it is visible during START.
          state       <= S_START;
          stage_start <= onehot(idx);
        end
        S_START: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Done takes priority over an expiring watchdog.
          if (done_sel) begin
            if (idx == LAST_IDX) begin
              class_out    <= class_in;
              result_valid <= 1'b1;
              state        <= S_RESULT;
            end else begin
              idx         <= idx_next;
              stage_start <= onehot(idx_next);
              state       <= S_START;
            end
          end else if (timer == TMR_LAST) begin
            timeout_err <= 1'b1;
            err_stage   <= idx;
            state       <= S_ERROR;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        S_RESULT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            img_count    <= img_count + CNT_W'(1);
            state        <= S_IDLE;
          end
        end
        S_ERROR: begin
          // err_stage is left as a record of the last failing stage.
          if (err_clear) begin
            timeout_err <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lenet_layer_sequencer.sv
// Directed bench for lenet_layer_sequencer with 3 stages, a 16-cycle
// watchdog and a 2-bit image counter. Cycle 0 is the handshake cycle of
// each image; a simple stage model returns done a set number of cycles
// after each start pulse.
module tb_lenet_layer_sequencer;

  localparam int NS = 3;
  localparam int IW = 2;
  localparam int TO = 16;
  localparam int TW = 5;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          img_valid;
  logic          img_ready;
  logic          img_load;
  logic [NS-1:0] stage_start;
  logic [NS-1:0] stage_done;
  logic [3:0]    class_in;
  logic [3:0]    class_out;
  logic          result_valid;
  logic          result_ready;
  logic          busy;
  logic          timeout_err;
  logic [IW-1:0] err_stage;
  logic          err_clear;
  logic [CW-1:0] img_count;
  logic [2:0]    state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  // Stage model state and per-run event records.
  int cyc;
  int lat[NS];
  bit respond[NS];
  int pend[NS];
  bit stale_en;
  bit stale_hold;
  int load_cyc, load_n, start_n, rv_cyc, err_cyc, err_stg, rv_class;
  int start_cyc[NS];

  logic [CW-1:0] exp_q[$];

  lenet_layer_sequencer #(
    .NUM_STAGES(NS), .IDX_W(IW), .TIMEOUT(TO), .TMR_W(TW), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .img_valid(img_valid), .img_ready(img_ready),
    .img_load(img_load), .stage_start(stage_start), .stage_done(stage_done),
    .class_in(class_in), .class_out(class_out), .result_valid(result_valid),
    .result_ready(result_ready), .busy(busy), .timeout_err(timeout_err),
    .err_stage(err_stage), .err_clear(err_clear), .img_count(img_count),
    .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
  endtask

  // Advance one cycle, sample 1ns after the edge, then update the stage model.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NS; i++)
      if (stage_start[i]) pend[i] = cyc + lat[i];
    for (int i = 0; i < NS; i++) begin
      bit d;
      d = respond[i] && (pend[i] == cyc);
      if (i == 0 && stale_en && d) stale_hold = 1'b1;
      stage_done[i] = d || (i == 0 && stale_hold);
    end
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    img_valid    = 1'b0;
    result_ready = 1'b0;
    err_clear    = 1'b0;
    stage_done   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  // Run one image from a handshake at cycle 0 for ncyc cycles, recording events.
  task automatic run(input int ncyc, input int ready_at, input int clear_at);
    cyc = 0;
    stale_hold = 1'b0;
    for (int i = 0; i < NS; i++) begin
      pend[i] = -1;
      start_cyc[i] = -1;
    end
    load_cyc = -1; load_n = 0; start_n = 0; rv_cyc = -1; err_cyc = -1;
    err_stg = -1; rv_class = -1;
    img_valid = 1'b1;
    repeat (ncyc) begin
      tick();
      img_valid    = 1'b0;
      result_ready = (cyc == ready_at);
      err_clear    = (cyc == clear_at);
      if (img_load) begin
        load_n++;
        if (load_cyc < 0) load_cyc = cyc;
      end
      for (int i = 0; i < NS; i++)
        if (stage_start[i]) begin
          start_n++;
          if (start_cyc[i] < 0) start_cyc[i] = cyc;
        end
      if (result_valid && rv_cyc < 0) begin
        rv_cyc = cyc;
        rv_class = int'(class_out);
      end
      if (timeout_err && err_cyc < 0) begin
        err_cyc = cyc;
        err_stg = int'(err_stage);
      end
    end
  endtask

  task automatic check_nominal(input string tag, input int exp_cnt);
    check({tag, "_load"}, load_cyc, 1);
    check({tag, "_start0"}, start_cyc[0], 2);
    check({tag, "_start1"}, start_cyc[1], 7);
    check({tag, "_start2"}, start_cyc[2], 12);
    check({tag, "_nstart"}, start_n, 3);
    check({tag, "_rv"}, rv_cyc, 17);
    check({tag, "_class"}, rv_class, 4);
    check({tag, "_count"}, img_count, exp_cnt);
    check({tag, "_ready"}, img_ready, 1);
    check({tag, "_rvlow"}, result_valid, 0);
  endtask

  initial begin
    int prev_load, loads, results;
    bit chk_next;
    class_in = 4'h4;
    stale_en = 1'b0;
    for (int i = 0; i < NS; i++) begin
      lat[i] = 4;
      respond[i] = 1'b1;
      pend[i] = -1;
    end

    // Reset state
    do_reset();
    check("rst_ready", img_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_start", stage_start, 0);
    check("rst_load", img_load, 0);
    check("rst_rv", result_valid, 0);
    check("rst_err", timeout_err, 0);
    check("rst_count", img_count, 0);
    check("rst_class", class_out, 0);

    // Nominal image
    run(20, 19, -1);
    check_nominal("nom", 1);

    // Stale done on stage 0 must not advance later stages
    stale_en = 1'b1;
    run(20, 19, -1);
    check_nominal("stale", 2);
    stale_en = 1'b0;

    // Stage 1 never answers: watchdog fires after 16 WAIT cycles
    respond[1] = 1'b0;
    run(32, -1, 30);
    check("to_start1", start_cyc[1], 7);
    check("to_err_cyc", err_cyc, 24);
    check("to_err_stage", err_stg, 1);
    check("to_nstart", start_n, 2);
    check("to_rv", rv_cyc, -1);
    check("to_cleared", timeout_err, 0);
    check("to_ready", img_ready, 1);
    check("to_stage_kept", err_stage, 1);
    check("to_count", img_count, 2);
    respond[1] = 1'b1;

    // Done arrives on the last allowed WAIT cycle of stage 0
    lat[0] = 16;
    run(31, 30, -1);
    check("tie_start1", start_cyc[1], 19);
    check("tie_start2", start_cyc[2], 24);
    check("tie_rv", rv_cyc, 29);
    check("tie_err", err_cyc, -1);
    check("tie_count", img_count, 3);
    lat[0] = 4;

    // Asynchronous reset in WAIT of stage 2
    run(14, -1, -1);
    check("mid_busy", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_start", stage_start, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", img_ready, 1);
    check("arst_rv", result_valid, 0);
    check("arst_class", class_out, 0);
    check("arst_err_stage", err_stage, 0);
    check("arst_count", img_count, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    run(20, 19, -1);
    check_nominal("post_rst", 1);

    // Counter wrap with back-to-back images, img_valid held high throughout
    do_reset();
    exp_q = {2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    cyc = 0;
    for (int i = 0; i < NS; i++) pend[i] = -1;
    prev_load = -1; loads = 0; results = 0; chk_next = 1'b0;
    img_valid = 1'b1;
    result_ready = 1'b1;
    for (int k = 0; k < 120 && exp_q.size() > 0; k++) begin
      tick();
      if (img_load) begin
        if (prev_load >= 0) check("wrap_period", cyc - prev_load, 18);
        prev_load = cyc;
        loads++;
      end
      if (chk_next) begin
        check("wrap_count", img_count, exp_q.pop_front());
        chk_next = 1'b0;
      end
      if (result_valid) begin
        chk_next = 1'b1;
        results++;
        if (results == 5) img_valid = 1'b0;
      end
    end
    check("wrap_left", exp_q.size(), 0);
    check("wrap_loads", loads, 5);
    result_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lenet_layer_sequencer.md
Name: lenet_layer_sequencer

Overview:
Top-level control FSM for the LeNet inference datapath. It accepts one 32x32 image per handshake, then issues a one-cycle start to each layer stage in order (conv1, pool1, conv2, pool2, conv3, fc1, fc2) and waits for each stage's done before starting the next. It captures the 4-bit class from the final stage and holds it until the consumer acknowledges. A per-stage watchdog flags hung stages, so hosts and benches wait on handshakes rather than fixed cycle budgets.

Parameters:
NUM_STAGES, 7, number of sequenced layer stages (indices 0..NUM_STAGES-1).
IDX_W, 3, width of the stage index; must satisfy 2^IDX_W >= NUM_STAGES.
TIMEOUT, 200000, maximum cycles spent in WAIT for one stage before an error is raised; must be >= 2.
TMR_W, 18, watchdog counter width; must satisfy 2^TMR_W > TIMEOUT.
CNT_W, 16, width of the completed-image counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
img_valid  in  1  a new image is present on the datapath input bus.
img_ready  out  1  sequencer can accept an image; equals (state==IDLE).
img_load  out  1  one-cycle pulse telling the datapath to latch its input image.
stage_start  out  NUM_STAGES  one-hot, one-cycle start pulse for stage idx.
stage_done  in  NUM_STAGES  per-stage done; only bit idx is sampled, and only in WAIT.
class_in  in  4  class index from the final stage; sampled when the last stage's done is accepted.
class_out  out  4  captured class.
result_valid  out  1  class_out is valid.
result_ready  in  1  consumer accepts the result.
busy  out  1  high whenever state != IDLE.
timeout_err  out  1  sticky watchdog error flag.
err_stage  out  IDX_W  stage index that timed out.
err_clear  in  1  clears an error and returns the FSM to IDLE.
img_count  out  CNT_W  count of completed results; wraps to 0.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, idx=0, timer=0. All of stage_start, img_load, class_out, result_valid, timeout_err, err_stage and img_count are 0. busy=0 and img_ready=1 (decoded from IDLE).
- Reset asserted mid-operation aborts the image immediately; stage_start drops in the same cycle. No partial result is produced.
- States: IDLE, LOAD, START, WAIT, RESULT, ERROR.
- IDLE: when img_valid & img_ready, go to LOAD; idx=0.
- LOAD: img_load=1 for exactly this one cycle; go to START.
- START: stage_start[idx]=1 for exactly this one cycle; timer=0; go to WAIT.
- WAIT, stage_done[idx]=1:
  - If idx < NUM_STAGES-1: idx=idx+1 and go to START.
  - If idx == NUM_STAGES-1: class_out=class_in and go to RESULT.
- WAIT, no done: timer increments. When timer == TIMEOUT-1 with no done, go to ERROR with timeout_err=1 and err_stage=idx. If done and the timeout occur in the same cycle, done wins.
- WAIT ignores stage_done bits other than idx. A done level left high from a previous stage has no effect on the next stage until that stage's own bit is sampled.
- RESULT: result_valid=1 and class_out stable. On result_ready=1: result_valid=0, img_count=img_count+1 (mod 2^CNT_W), go to IDLE. result_ready outside RESULT is ignored.
- ERROR: outputs held, no start pulses. On err_clear=1: timeout_err=0, go to IDLE. err_stage keeps its value until the next error or reset. img_count is unchanged.
- img_valid is ignored outside IDLE; there is no queueing.
- Timing from handshake edge T: img_load at T+1, stage_start[0] at T+2, first done sampled at T+3. After stage_done[idx] is accepted at cycle d, the next start (or result_valid) occurs at d+1. Overhead is 2 + NUM_STAGES cycles per image plus the stage latencies.
- Outputs are registered except img_ready and busy, which are state decodes.

Test Plan:
- Nominal (NUM_STAGES=3, TIMEOUT=16): img_valid at cycle 0; each stage's done returns 4 cycles after its start; class_in=4'h4. Expect img_load at 1, starts at 2/7/12, result_valid at 17 with class_out=4. result_ready at 19 -> img_count=1, img_ready=1 at 20.
- Stale done: hold stage_done[0]=1 permanently during the nominal run. Expect stage 1 still waits for its own done; timing is identical to the nominal case.
- Timeout (TIMEOUT=16): stage 1 never responds. Expect timeout_err=1 and err_stage=1 on the 16th WAIT cycle, with no further starts. err_clear -> IDLE, timeout_err=0, img_count unchanged.
- Done/timeout tie: stage_done[0] arrives on the same cycle timer==15. Expect the stage to advance and no error.
- Reset mid-WAIT of stage 2: all outputs reach their reset values asynchronously. After release, a fresh image completes normally and img_count=1.
- Wrap (CNT_W=2): run 5 images back-to-back with result_ready tied to 1. Expect img_count to read 1,2,3,0,1, with img_valid ignored while busy.
